// File: rtl/ensamblador_numeros.sv
// Assembles a decimal ASCII number from UART bytes into a 32-bit unsigned value.
// A TERMINATOR byte ends each number: a clean number pulses value_valid, a rejected one pulses error.
module ensamblador_numeros #(
   parameter logic [7:0] TERMINATOR = 8'h0D,
   parameter int         MAX_DIGITS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic [31:0] value_out,
   output logic        value_valid,
   output logic        error,
   output logic        busy
);

   localparam int CW = $clog2(MAX_DIGITS + 2);
   localparam logic [CW-1:0] MAXC = CW'(MAX_DIGITS);

   typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

   state_t        state, state_nx;
   logic [31:0]   acc, acc_nx;
   logic [CW-1:0] count, count_nx;
   logic [31:0]   value_nx;
   logic          valid_nx, error_nx;

   logic          is_digit, is_term, is_lf;
   logic [3:0]    digit;
   logic [35:0]   acc_x10;

   assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_term  = (rx_data == TERMINATOR);
   assign is_lf    = (rx_data == 8'h0A);
   assign digit    = rx_data[3:0];
   // Widened so a 33rd..36th bit reveals overflow past 32'hFFFFFFFF
   assign acc_x10  = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {32'd0, digit};

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         acc         <= '0;
         count       <= '0;
         value_out   <= '0;
         value_valid <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_nx;
         acc         <= acc_nx;
         count       <= count_nx;
         value_out   <= value_nx;
         value_valid <= valid_nx;
         error       <= error_nx;
      end
   end

   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      count_nx = count;
      value_nx = value_out;
      valid_nx = 1'b0;
      error_nx = 1'b0;
      if (rx_done) begin
         case (state)
            IDLE: begin
               if (is_digit) begin
                  acc_nx   = {28'd0, digit};
                  count_nx = CW'(1);
                  state_nx = ACCUM;
               end else if (!is_term && !is_lf) begin
                  state_nx = DISCARD;
               end
            end
            ACCUM: begin
               if (is_digit) begin
                  if ((acc_x10[35:32] != 4'd0) || (count >= MAXC)) begin
                     state_nx = DISCARD;
                  end else begin
                     acc_nx   = acc_x10[31:0];
                     count_nx = count + CW'(1);
                  end
               end else if (is_term) begin
                  value_nx = acc;
                  valid_nx = 1'b1;
                  state_nx = IDLE;
               end else begin
                  state_nx = DISCARD;
               end
            end
            DISCARD: begin
               if (is_term) begin
                  error_nx = 1'b1;
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ensamblador_numeros.sv
// Bench for ensamblador_numeros: directed lines plus random lines checked against a line-level parser model.
module tb_ensamblador_numeros;

   typedef byte unsigned bq_t[$];

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_done = 1'b0;
   logic [31:0] value_out;
   logic        value_valid, error, busy;

   int tests = 0;
   int fails = 0;
   int nvalid = 0, nerr = 0, nboth = 0;
   int exp_valid = 0, exp_err = 0;
   logic [31:0] model_value = 32'd0;

   ensamblador_numeros dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .value_out(value_out), .value_valid(value_valid), .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulses are counted at the edge that ends them
   always @(posedge clk) begin
      if (value_valid) nvalid++;
      if (error) nerr++;
      if (value_valid && error) nboth++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bq_t s2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   // Enter and leave at a negedge; the posedge in between consumes the byte.
   task automatic send_byte(input byte unsigned b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
   endtask

   // Whole-line reference: leading LFs are ignored, an empty line does nothing,
   // otherwise the line is a number only if it is all digits, short enough and fits 32 bits.
   task automatic model_line(input bq_t body, output bit v, output bit e, output logic [31:0] val);
      int s = 0;
      longint unsigned n = 0;
      bit ok = 1'b1;
      while (s < body.size() && body[s] == 8'h0A) s++;
      v = 1'b0; e = 1'b0; val = 32'd0;
      if (s == body.size()) return;
      if (body.size() - s > 10) ok = 1'b0;
      for (int i = s; i < body.size(); i++) begin
         if (body[i] < 8'h30 || body[i] > 8'h39) ok = 1'b0;
         else if (ok) n = n * 10 + longint'(body[i] - 8'h30);
      end
      if (ok && n > 64'hFFFFFFFF) ok = 1'b0;
      if (ok) begin v = 1'b1; val = n[31:0]; end
      else e = 1'b1;
   endtask

   task automatic send_line(input string tag, input bq_t body, input bit gaps);
      bit v, e, taken = 1'b0;
      logic [31:0] val;
      model_line(body, v, e, val);
      for (int i = 0; i < body.size(); i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            rx_done = 1'b0;
            rx_data = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         send_byte(body[i]);
         if (body[i] != 8'h0A) taken = 1'b1;
         check({tag, ":busy"}, {31'd0, busy}, {31'd0, taken});
      end
      send_byte(8'h0D);
      rx_done = 1'b0;
      if (v) begin model_value = val; exp_valid++; end
      if (e) exp_err++;
      check({tag, ":valid"}, {31'd0, value_valid}, {31'd0, v});
      check({tag, ":error"}, {31'd0, error}, {31'd0, e});
      check({tag, ":value"}, value_out, model_value);
      check({tag, ":idle"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({tag, ":pulse_end"}, {30'd0, value_valid, error}, 32'd0);
      check({tag, ":nvalid"}, nvalid, exp_valid);
      check({tag, ":nerr"}, nerr, exp_err);
   endtask

   function automatic bq_t rand_digits(input int len);
      bq_t q;
      for (int i = 0; i < len; i++) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
      return q;
   endfunction

   initial begin
      bq_t q;
      byte unsigned junk;
      longint unsigned lv;

      #12;
      check("reset:value", value_out, 32'd0);
      check("reset:flags", {29'd0, value_valid, error, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      send_line("max10", s2q("1234567898"), 1'b0);
      check("max10:const", value_out, 32'h499602DA);
      send_line("n43", s2q("43"), 1'b1);
      send_line("umax", s2q("4294967295"), 1'b0);
      check("umax:const", value_out, 32'hFFFFFFFF);
      send_line("ovf", s2q("4294967296"), 1'b0);
      check("ovf:hold", value_out, 32'hFFFFFFFF);
      send_line("junk", s2q("12a3"), 1'b0);
      send_line("seven", s2q("7"), 1'b0);
      send_line("zeros", s2q("0007"), 1'b1);
      send_line("toolong", s2q("00000000001"), 1'b0);
      send_line("empty_cr", s2q(""), 1'b0);
      send_line("empty_lf", s2q("\n"), 1'b0);
      send_line("lf_lead", s2q("\n\n42"), 1'b0);
      send_line("lf_mid", s2q("4\n2"), 1'b0);
      send_line("b2b99", s2q("99"), 1'b0);
      check("b2b99:const", value_out, 32'd99);

      // Abandon a partial number with reset; first edge after release carries a digit
      send_byte(8'h31);
      send_byte(8'h32);
      rx_done = 1'b0;
      check("partial:busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("async_rst:flags", {29'd0, value_valid, error, busy}, 32'd0);
      check("async_rst:value", value_out, 32'd0);
      model_value = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      send_line("post_rst", s2q("5"), 1'b0);
      check("post_rst:const", value_out, 32'd5);

      for (int t = 0; t < 60; t++) begin
         q.delete();
         case ($urandom_range(0, 4))
            0: q = rand_digits($urandom_range(1, 12));
            1: begin
               lv = 64'hFFFFFFFF - 5 + longint'($urandom_range(0, 10));
               q = s2q($sformatf("%0d", lv));
            end
            2: begin
               q = s2q($sformatf("%0d", $urandom));
               repeat ($urandom_range(0, 3)) q.push_front(8'h30);
            end
            3: begin
               q = rand_digits($urandom_range(1, 6));
               junk = 8'($urandom_range(0, 255));
               if (junk == 8'h0D) junk = 8'h78;
               q.insert($urandom_range(0, q.size()), junk);
            end
            default: begin
               q = rand_digits($urandom_range(1, 9));
               repeat ($urandom_range(1, 2)) q.push_front(8'h0A);
            end
         endcase
         send_line($sformatf("rnd%0d", t), q, 1'($urandom_range(0, 1)));
      end

      check("never_both", nboth, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ensamblador_numeros.md
ENSAMBLADOR_NUMEROS -- requirements
Module: ensamblador_numeros

Interface
REQ-001 SHALL have parameter TERMINATOR, default 8'h0D, ASCII byte that ends a number.
REQ-002 SHALL have parameter MAX_DIGITS, default 10, maximum digit count accepted per number.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port rx_data  input  8  received byte from UART receiver; sampled only when rx_done=1.
REQ-006 SHALL have port rx_done  input  1  one-cycle pulse marking a new valid rx_data byte.
REQ-007 SHALL have port value_out  output  32  last successfully assembled unsigned number; held until next success.
REQ-008 SHALL have port value_valid  output  1  one-cycle pulse when value_out is updated.
REQ-009 SHALL have port error  output  1  one-cycle pulse when a number is rejected.
REQ-010 SHALL have port busy  output  1  high while at least one byte of the current number has been taken.

Function
REQ-011 SHALL implement FSM states IDLE, ACCUM, DISCARD; one byte processed per rx_done pulse; rx_done=0 cycles change nothing.
REQ-012 SHALL, in IDLE, on digit '0'-'9' (8'h30-8'h39): load acc = digit value, count = 1, go to ACCUM.
REQ-013 SHALL, in IDLE, ignore TERMINATOR and 8'h0A (empty line produces no pulse, stays IDLE).
REQ-014 SHALL, in IDLE, on any other byte go to DISCARD.
REQ-015 SHALL, in ACCUM, on digit: compute acc*10 + digit in 36-bit width as (acc<<3)+(acc<<1)+digit; count+1.
REQ-016 SHALL go to DISCARD if that result exceeds 32'hFFFFFFFF or count would exceed MAX_DIGITS; acc unchanged.
REQ-017 SHALL, in ACCUM, on TERMINATOR: value_out <= acc, value_valid=1 on the next cycle after the rx_done cycle, go to IDLE.
REQ-018 SHALL, in ACCUM, on 8'h0A or any non-digit non-TERMINATOR byte, go to DISCARD.
REQ-019 SHALL, in DISCARD, drop all bytes until TERMINATOR, then pulse error=1 on the next cycle and go to IDLE.
REQ-020 SHALL accept leading zeros as digits (count toward MAX_DIGITS); "0007" yields 7.
REQ-021 SHALL never assert value_valid and error in the same cycle.
REQ-022 SHALL assert busy=1 in ACCUM and DISCARD, 0 in IDLE.
REQ-023 SHALL accept rx_done pulses on consecutive cycles without loss (one byte per cycle throughput).
REQ-024 SHALL keep value_out unchanged on error or empty line.

Reset
REQ-025 SHALL, while reset=0, force state IDLE, acc=0, count=0, value_out=0, value_valid=0, error=0, busy=0, asynchronously.
REQ-026 SHALL abandon a partially received number on reset with no value_valid or error pulse.
REQ-027 SHALL process an rx_done pulse arriving in the first clock edge after reset deassertion normally.

Verification
REQ-028 SHALL cover: bytes "1234567898",0x0D -> value_out=1234567898 (32'h499602DA), one value_valid pulse one cycle after the 0x0D byte.
REQ-029 SHALL cover: "43",0x0D then "4294967295",0x0D -> value_valid twice, value_out 43 then 32'hFFFFFFFF.
REQ-030 SHALL cover: "4294967296",0x0D -> error pulse, no value_valid, value_out retains previous value.
REQ-031 SHALL cover: "12a3",0x0D -> error pulse; following "7",0x0D -> value_out=7, value_valid.
REQ-032 SHALL cover: "12" then reset low 3 cycles, then "5",0x0D -> value_out=5, no error pulse at any point.
REQ-033 SHALL cover: lone 0x0D and 0x0A bytes, back-to-back rx_done pulses "99",0x0D -> only one value_valid, value_out=99.
